// File: rtl/div_pkg.sv
// Shared types for the restoring divider: FSM states and counter sizing.
// ROUND exists only when DIV_ROUND_EN is defined.
package div_pkg;

  localparam int DIV_W_DEF = 32;
  localparam int DIV_CNT_W = $clog2(DIV_W_DEF) + 1;

  // Counter width for an arbitrary operand width (same rule as DIV_CNT_W).
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    DONE  = 2'd2
`ifdef DIV_ROUND_EN
    ,ROUND = 2'd3
`endif
  } div_state_e;

endpackage

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negate: dout = neg ? -din : din. Purely combinational.
module div_abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/div_subshift_hs.sv
// Valid/ready restoring divider, one quotient bit per cycle; out_valid DATA_W+1 cycles after accept
// (2 for a zero divisor), results held until out_ready. DIV_ROUND_EN adds a round-half-away ROUND cycle.
module div_subshift_hs
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              signed_op,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_by_zero
);

  localparam int CNT_W = cnt_width(DATA_W);

  div_state_e        state_q, state_d;
  logic [DATA_W-1:0] quo_q, rem_q, dvs_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              q_neg_q, r_neg_q, dz_q, fin_q;

  logic              a_neg, b_neg, accept, hshake, last_step, ge;
  logic [DATA_W-1:0] a_mag, b_mag, q_fix, r_fix, rem_nxt, quo_nxt;
  logic [DATA_W:0]   shifted, diff;

  assign a_neg = signed_op & dividend[DATA_W-1];
  assign b_neg = signed_op & divisor[DATA_W-1];

  div_abs_neg #(.W(DATA_W)) u_mag_a (.din(dividend), .neg(a_neg),   .dout(a_mag));
  div_abs_neg #(.W(DATA_W)) u_mag_b (.din(divisor),  .neg(b_neg),   .dout(b_mag));
  div_abs_neg #(.W(DATA_W)) u_fix_q (.din(quo_q),    .neg(q_neg_q), .dout(q_fix));
  div_abs_neg #(.W(DATA_W)) u_fix_r (.din(rem_q),    .neg(r_neg_q), .dout(r_fix));

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign hshake    = out_valid && out_ready;
  assign last_step = (state_q == CALC) && (cnt_q == CNT_W'(DATA_W - 1));

  // Restoring step: shift the next dividend bit into the partial remainder, keep the difference if non-negative.
  assign shifted = {rem_q, quo_q[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign ge      = ~diff[DATA_W];
  assign rem_nxt = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  assign quo_nxt = {quo_q[DATA_W-2:0], ge};

`ifdef DIV_ROUND_EN
  logic round_up;
  assign round_up = ({rem_q, 1'b0} >= {1'b0, dvs_q});
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (divisor == '0) ? DONE : CALC;
      CALC: if (last_step) begin
`ifdef DIV_ROUND_EN
        state_d = ROUND;
`else
        state_d = DONE;
`endif
      end
`ifdef DIV_ROUND_EN
      ROUND: state_d = DONE;
`endif
      DONE: if (hshake) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dz_q        <= 1'b0;
      fin_q       <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          quo_q   <= a_mag;
          rem_q   <= '0;
          dvs_q   <= b_mag;
          cnt_q   <= '0;
          q_neg_q <= a_neg ^ b_neg;
          r_neg_q <= a_neg;
          dz_q    <= (divisor == '0);
          fin_q   <= 1'b0;
        end
        CALC: begin
          quo_q <= quo_nxt;
          rem_q <= rem_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
`ifndef DIV_ROUND_EN
          if (last_step) fin_q <= 1'b1;
`endif
        end
`ifdef DIV_ROUND_EN
        ROUND: begin
          if (round_up) quo_q <= quo_q + DATA_W'(1);
          fin_q <= 1'b1;
        end
`endif
        DONE: begin
          if (!fin_q) begin
            // Zero divisor: stage all-ones / dividend magnitude so the normal fix-up restores the dividend.
            quo_q   <= '1;
            rem_q   <= quo_q;
            q_neg_q <= 1'b0;
            fin_q   <= 1'b1;
          end else if (!out_valid) begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= dz_q;
            out_valid   <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
